// File: rtl/mmu_client_port_pkg.sv
// Shared MMU widths and the response-path types used by the client port.
package mmu_client_port_pkg;

    localparam int REQ_ID_WIDTH        = 13;
    localparam int ALL_PAGE_IDX_WIDTH  = 16;
    localparam int REQ_SIZE_TYPE_WIDTH = 8;
    localparam int FAIL_REASON_WIDTH   = 3;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_POP_WAIT,
        RSP_HOLD
    } rsp_state_t;

    typedef struct packed {
        logic                          is_free;
        logic [REQ_ID_WIDTH-1:0]       id;
        logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
        logic                          fail;
        logic [FAIL_REASON_WIDTH-1:0]  fail_reason;
    } rsp_t;

endpackage

// File: rtl/mmu_client_port.sv
// Client-side adapter to the MMU: forwards alloc/free requests with a shared ID,
// bounds outstanding work and serialises alloc/free responses with a fair arbiter.
module mmu_client_port
    import mmu_client_port_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cli_req_valid,
    output logic                           cli_req_ready,
    input  logic                           cli_req_is_free,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0]  cli_req_page_idx,
    input  logic [REQ_SIZE_TYPE_WIDTH-1:0] cli_req_page_count,
    output logic                           cli_rsp_valid,
    input  logic                           cli_rsp_ready,
    output logic                           cli_rsp_is_free,
    output logic [REQ_ID_WIDTH-1:0]        cli_rsp_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0]  cli_rsp_page_idx,
    output logic                           cli_rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0]   cli_rsp_fail_reason,
    output logic                           alloc_req_submit,
    output logic                           free_req_submit,
    output logic [REQ_ID_WIDTH-1:0]        mmu_req_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0]  mmu_req_page_idx,
    output logic [REQ_SIZE_TYPE_WIDTH-1:0] mmu_req_page_count,
    input  logic                           alloc_req_fifo_full,
    input  logic                           free_req_fifo_full,
    input  logic                           alloc_rsp_fifo_not_empty,
    input  logic                           free_rsp_fifo_not_empty,
    output logic                           alloc_rsp_pop,
    output logic                           free_rsp_pop,
    input  logic [REQ_ID_WIDTH-1:0]        alloc_rsp_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0]  alloc_rsp_page_idx,
    input  logic                           alloc_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]   alloc_rsp_fail_reason,
    input  logic [REQ_ID_WIDTH-1:0]        free_rsp_id,
    input  logic                           free_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]   free_rsp_fail_reason
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic [REQ_ID_WIDTH-1:0] id_cnt;
    logic [OUT_W-1:0]        outstanding;
    logic                    sel_full;
    logic                    accept;
    logic                    rsp_hs;
    logic                    any_ne;
    logic                    pick_free;
    logic                    last_free;
    rsp_state_t              state;
    rsp_state_t              state_next;
    rsp_t                    rsp_q;

    // Combinational outputs are gated by rst_n so every output reads 0 during reset.
    assign sel_full           = cli_req_is_free ? free_req_fifo_full : alloc_req_fifo_full;
    assign cli_req_ready      = rst_n && (outstanding < OUT_MAX) && !sel_full;
    assign accept             = cli_req_valid && cli_req_ready;
    assign alloc_req_submit   = accept && !cli_req_is_free;
    assign free_req_submit    = accept && cli_req_is_free;
    assign mmu_req_id         = id_cnt;
    assign mmu_req_page_idx   = rst_n ? cli_req_page_idx : '0;
    assign mmu_req_page_count = rst_n ? cli_req_page_count : '0;
    assign rsp_hs             = cli_rsp_valid && cli_rsp_ready;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_cnt      <= '0;
            outstanding <= '0;
        end else begin
            if (accept) id_cnt <= id_cnt + 1'b1;
            case ({accept, rsp_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // With both sources pending, serve the one not served last time.
    assign any_ne    = alloc_rsp_fifo_not_empty || free_rsp_fifo_not_empty;
    assign pick_free = (alloc_rsp_fifo_not_empty && free_rsp_fifo_not_empty)
                     ? !last_free : free_rsp_fifo_not_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RSP_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            RSP_IDLE:     if (any_ne) state_next = RSP_POP_WAIT;
            RSP_POP_WAIT: state_next = RSP_HOLD;
            RSP_HOLD:     if (cli_rsp_ready) state_next = RSP_IDLE;
            default:      state_next = RSP_IDLE;
        endcase
    end

    always_comb begin
        alloc_rsp_pop = 1'b0;
        free_rsp_pop  = 1'b0;
        cli_rsp_valid = 1'b0;
        case (state)
            RSP_IDLE: begin
                alloc_rsp_pop = rst_n && any_ne && !pick_free;
                free_rsp_pop  = rst_n && any_ne && pick_free;
            end
            RSP_HOLD: cli_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // last_free doubles as the source of the response in flight; it resets to "free" so alloc wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_free <= 1'b1;
            rsp_q     <= '0;
        end else begin
            if (state == RSP_IDLE && any_ne) last_free <= pick_free;
            if (state == RSP_POP_WAIT) begin
                if (last_free)
                    rsp_q <= '{is_free: 1'b1, id: free_rsp_id, page_idx: '0,
                               fail: free_rsp_fail, fail_reason: free_rsp_fail_reason};
                else
                    rsp_q <= '{is_free: 1'b0, id: alloc_rsp_id, page_idx: alloc_rsp_page_idx,
                               fail: alloc_rsp_fail, fail_reason: alloc_rsp_fail_reason};
            end
        end
    end

    assign cli_rsp_is_free     = rsp_q.is_free;
    assign cli_rsp_id          = rsp_q.id;
    assign cli_rsp_page_idx    = rsp_q.page_idx;
    assign cli_rsp_fail        = rsp_q.fail;
    assign cli_rsp_fail_reason = rsp_q.fail_reason;

endmodule

// File: tb/tb_mmu_client_port.sv
// Directed bench for mmu_client_port: a default instance plus a MAX_OUTSTANDING=2 instance.
module tb_mmu_client_port;
    import mmu_client_port_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cli_req_valid = 1'b0, cli_req_is_free = 1'b0, cli_rsp_ready = 1'b0;
    logic [ALL_PAGE_IDX_WIDTH-1:0]  cli_req_page_idx = '0;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] cli_req_page_count = '0;
    logic alloc_full = 1'b0, free_full = 1'b0;
    logic alloc_ne = 1'b0, free_ne = 1'b0, b_alloc_ne = 1'b0;
    logic [REQ_ID_WIDTH-1:0]       alloc_rsp_id = '0, free_rsp_id = '0;
    logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx = '0;
    logic alloc_rsp_fail = 1'b0, free_rsp_fail = 1'b0;
    logic [FAIL_REASON_WIDTH-1:0] alloc_rsp_fail_reason = '0, free_rsp_fail_reason = '0;

    logic a_ready, a_rsp_valid, a_rsp_is_free, a_rsp_fail, a_alloc_sub, a_free_sub, a_alloc_pop, a_free_pop;
    logic [REQ_ID_WIDTH-1:0]        a_rsp_id, a_req_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0]  a_rsp_page, a_req_page;
    logic [FAIL_REASON_WIDTH-1:0]   a_rsp_reason;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] a_req_count;

    logic b_ready, b_rsp_valid, b_rsp_is_free, b_rsp_fail, b_alloc_sub, b_free_sub, b_alloc_pop, b_free_pop;
    logic [REQ_ID_WIDTH-1:0]        b_rsp_id, b_req_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0]  b_rsp_page, b_req_page;
    logic [FAIL_REASON_WIDTH-1:0]   b_rsp_reason;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] b_req_count;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mmu_client_port dut_a (
        .clk(clk), .rst_n(rst_n),
        .cli_req_valid(cli_req_valid), .cli_req_ready(a_ready), .cli_req_is_free(cli_req_is_free),
        .cli_req_page_idx(cli_req_page_idx), .cli_req_page_count(cli_req_page_count),
        .cli_rsp_valid(a_rsp_valid), .cli_rsp_ready(cli_rsp_ready), .cli_rsp_is_free(a_rsp_is_free),
        .cli_rsp_id(a_rsp_id), .cli_rsp_page_idx(a_rsp_page), .cli_rsp_fail(a_rsp_fail),
        .cli_rsp_fail_reason(a_rsp_reason),
        .alloc_req_submit(a_alloc_sub), .free_req_submit(a_free_sub), .mmu_req_id(a_req_id),
        .mmu_req_page_idx(a_req_page), .mmu_req_page_count(a_req_count),
        .alloc_req_fifo_full(alloc_full), .free_req_fifo_full(free_full),
        .alloc_rsp_fifo_not_empty(alloc_ne), .free_rsp_fifo_not_empty(free_ne),
        .alloc_rsp_pop(a_alloc_pop), .free_rsp_pop(a_free_pop),
        .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page_idx(alloc_rsp_page_idx),
        .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
        .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail), .free_rsp_fail_reason(free_rsp_fail_reason)
    );

    mmu_client_port #(.MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cli_req_valid(cli_req_valid), .cli_req_ready(b_ready), .cli_req_is_free(cli_req_is_free),
        .cli_req_page_idx(cli_req_page_idx), .cli_req_page_count(cli_req_page_count),
        .cli_rsp_valid(b_rsp_valid), .cli_rsp_ready(cli_rsp_ready), .cli_rsp_is_free(b_rsp_is_free),
        .cli_rsp_id(b_rsp_id), .cli_rsp_page_idx(b_rsp_page), .cli_rsp_fail(b_rsp_fail),
        .cli_rsp_fail_reason(b_rsp_reason),
        .alloc_req_submit(b_alloc_sub), .free_req_submit(b_free_sub), .mmu_req_id(b_req_id),
        .mmu_req_page_idx(b_req_page), .mmu_req_page_count(b_req_count),
        .alloc_req_fifo_full(alloc_full), .free_req_fifo_full(free_full),
        .alloc_rsp_fifo_not_empty(b_alloc_ne), .free_rsp_fifo_not_empty(1'b0),
        .alloc_rsp_pop(b_alloc_pop), .free_rsp_pop(b_free_pop),
        .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page_idx(alloc_rsp_page_idx),
        .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
        .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail), .free_rsp_fail_reason(free_rsp_fail_reason)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int acc;
        // Reset: outputs must be 0 even with inputs that would otherwise drive them.
        alloc_ne = 1'b1;
        cli_req_valid = 1'b1;
        cli_req_page_idx = 16'h00AA;
        repeat (2) cyc();
        settle();
        check("rst_ready", a_ready, 0);
        check("rst_pop", a_alloc_pop, 0);
        check("rst_submit", a_alloc_sub, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_req_id", a_req_id, 0);
        check("rst_req_page", a_req_page, 0);
        alloc_ne = 1'b0;
        cli_req_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        settle();
        check("post_rst_ready", a_ready, 1);

        // Three back-to-back allocs; the 2-deep instance refuses the third.
        for (int i = 0; i < 3; i++) begin
            cyc();
            cli_req_valid = 1'b1;
            cli_req_is_free = 1'b0;
            cli_req_page_count = 8'd3;
            cli_req_page_idx = 16'h0077;
            settle();
            check("b2b_alloc_sub", a_alloc_sub, 1);
            check("b2b_free_sub", a_free_sub, 0);
            check("b2b_req_id", a_req_id, i);
            check("b2b_page_count", a_req_count, 3);
            check("b2b_page_idx", a_req_page, 16'h0077);
            check("lim_b_ready", b_ready, (i < 2) ? 1 : 0);
            check("lim_b_submit", b_alloc_sub, (i < 2) ? 1 : 0);
        end
        cyc();
        cli_req_valid = 1'b0;

        // Both response sources pending: alloc first, then free, two cycles each to valid.
        alloc_ne = 1'b1;
        free_ne = 1'b1;
        cli_rsp_ready = 1'b1;
        alloc_rsp_id = 13'd5;
        alloc_rsp_page_idx = 16'h0123;
        free_rsp_id = 13'd7;
        free_rsp_fail = 1'b1;
        free_rsp_fail_reason = 3'd3;
        settle();
        check("arb_k0_alloc_pop", a_alloc_pop, 1);
        check("arb_k0_free_pop", a_free_pop, 0);
        check("arb_k0_valid", a_rsp_valid, 0);
        cyc(); settle();
        check("arb_k1_pops", {a_alloc_pop, a_free_pop}, 0);
        check("arb_k1_valid", a_rsp_valid, 0);
        cyc(); settle();
        check("arb_k2_valid", a_rsp_valid, 1);
        check("arb_k2_is_free", a_rsp_is_free, 0);
        check("arb_k2_id", a_rsp_id, 5);
        check("arb_k2_page", a_rsp_page, 16'h0123);
        check("arb_k2_fail", a_rsp_fail, 0);
        cyc(); settle();
        check("arb_k3_free_pop", a_free_pop, 1);
        check("arb_k3_alloc_pop", a_alloc_pop, 0);
        check("arb_k3_valid", a_rsp_valid, 0);
        cyc(); settle();
        check("arb_k4_valid", a_rsp_valid, 0);
        cyc(); settle();
        check("arb_k5_valid", a_rsp_valid, 1);
        check("arb_k5_is_free", a_rsp_is_free, 1);
        check("arb_k5_id", a_rsp_id, 7);
        check("arb_k5_page", a_rsp_page, 0);
        check("arb_k5_fail", a_rsp_fail, 1);
        check("arb_k5_reason", a_rsp_reason, 3);
        cyc();
        alloc_ne = 1'b0;
        free_ne = 1'b0;
        settle();
        check("arb_k6_pops", {a_alloc_pop, a_free_pop}, 0);

        // Response stays frozen in HOLD while the client stalls.
        cyc();
        alloc_ne = 1'b1;
        cli_rsp_ready = 1'b0;
        alloc_rsp_id = 13'd9;
        alloc_rsp_page_idx = 16'h0044;
        settle();
        check("hold_pop", a_alloc_pop, 1);
        cyc();
        alloc_ne = 1'b0;
        cyc(); settle();
        check("hold_valid0", a_rsp_valid, 1);
        check("hold_id0", a_rsp_id, 9);
        alloc_rsp_id = 13'd1;
        alloc_rsp_page_idx = 16'h0099;
        cyc(); settle();
        check("hold_valid1", a_rsp_valid, 1);
        check("hold_id1", a_rsp_id, 9);
        check("hold_page1", a_rsp_page, 16'h0044);
        check("hold_no_pop", a_alloc_pop, 0);
        cli_rsp_ready = 1'b1;
        cyc(); settle();
        check("hold_released", a_rsp_valid, 0);

        // Limit instance: ready returns the cycle after its first response handshake.
        b_alloc_ne = 1'b1;
        settle();
        check("lim_b_pop", b_alloc_pop, 1);
        cyc();
        b_alloc_ne = 1'b0;
        cyc(); settle();
        check("lim_b_rsp_valid", b_rsp_valid, 1);
        check("lim_b_ready_hs", b_ready, 0);
        cyc(); settle();
        check("lim_b_ready_back", b_ready, 1);

        // Full free FIFO blocks a free request; an alloc next cycle goes through.
        cyc();
        free_full = 1'b1;
        cli_req_valid = 1'b1;
        cli_req_is_free = 1'b1;
        settle();
        check("full_ready", a_ready, 0);
        check("full_free_sub", a_free_sub, 0);
        check("full_alloc_sub", a_alloc_sub, 0);
        cyc();
        cli_req_is_free = 1'b0;
        settle();
        check("full_alt_ready", a_ready, 1);
        check("full_alt_sub", a_alloc_sub, 1);
        check("full_alt_id", a_req_id, 3);
        cyc();
        free_full = 1'b0;
        cli_req_is_free = 1'b1;
        cli_req_page_idx = 16'h0055;
        cli_req_page_count = 8'd2;
        settle();
        check("free_sub", a_free_sub, 1);
        check("free_alloc_sub", a_alloc_sub, 0);
        check("free_id", a_req_id, 4);
        check("free_page", a_req_page, 16'h0055);
        check("free_count", a_req_count, 2);
        cyc();
        cli_req_is_free = 1'b0;
        settle();
        check("pre_rst_b_full", b_ready, 0);

        // Asynchronous reset mid-cycle clears the outstanding count and ID.
        #2;
        rst_n = 1'b0;
        settle();
        check("async_rst_ready", a_ready, 0);
        check("async_rst_id", a_req_id, 0);
        cyc();
        rst_n = 1'b1;
        settle();
        check("post_rst_b_ready", b_ready, 1);

        // ID wrap: stream allocs against a steady free-response drain until 8193 accepts.
        free_ne = 1'b1;
        cli_rsp_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 40000 && acc < 8193; c++) begin
            if (a_ready) begin
                if (acc == 8191) check("wrap_last_id", a_req_id, 8191);
                if (acc == 8192) check("wrap_zero_id", a_req_id, 0);
                acc++;
            end
            cyc(); settle();
        end
        check("wrap_reached", (acc >= 8193) ? 1 : 0, 1);
        cli_req_valid = 1'b0;
        free_ne = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
